// File: rtl/delay_arb_pkg.sv
// Shared types and helpers for the delay timer arbiter.
// Build option: DELAY_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package delay_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_IDX_W = 3;

  // Prescaler width; a 1 MHz clock still needs a one-bit counter.
  function automatic int unsigned presc_w(input int unsigned clk_mhz);
    return (clk_mhz > 1) ? $clog2(clk_mhz) : 1;
  endfunction

  // Round-robin pick: rotate so ptr is bit 0, find first set, rotate back.
  function automatic logic [MAX_IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0]   req,
                                                   input logic [MAX_IDX_W-1:0] ptr,
                                                   input logic [31:0]          n);
    logic [MAX_REQ-1:0]   rot;
    logic [MAX_IDX_W-1:0] first;
    logic [31:0]          idx;
    rot   = '0;
    first = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (32'(i) < n) begin
        idx    = (32'(ptr) + 32'(i)) % n;
        rot[i] = req[idx[MAX_IDX_W-1:0]];
      end
    end
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (rot[i]) first = MAX_IDX_W'(i);
    end
    idx = (32'(first) + 32'(ptr)) % n;
    return idx[MAX_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: counts 0..CLOCK_SPEED_MHZ-1 while enabled, tick_c marks the wrap cycle.
module us_tick_gen
  import delay_arb_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED_MHZ = 12
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned   PW   = presc_w(CLOCK_SPEED_MHZ);
  localparam logic [PW-1:0] LAST = PW'(CLOCK_SPEED_MHZ - 1);

  logic [PW-1:0] cnt;

  assign tick_c = en && (cnt == LAST);

  // Prescaler counter with synchronous clear taking precedence over counting.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick_c ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/delay_timer_arbiter.sv
// Shares one microsecond delay engine among NUM_REQ requesters.
// Build option: DELAY_ARB_FIXED_PRIO_EN gives fixed priority (lowest index wins), no rr pointer.
module delay_timer_arbiter
  import delay_arb_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED_MHZ = 12,
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DELAY_W         = 16
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DELAY_W-1:0] delay_us,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]         state, state_d;
  logic [NUM_REQ-1:0] grant_d, done_d;
  logic               busy_d;
  logic [DELAY_W-1:0] us_left, us_left_d;
  logic [IDX_W-1:0]   owner, owner_d;
  logic [IDX_W-1:0]   win_c;
  logic               presc_clr_c;
  logic               tick_c;

`ifdef DELAY_ARB_FIXED_PRIO_EN
  assign win_c = IDX_W'(rr_pick(MAX_REQ'(req), '0, 32'(NUM_REQ)));
`else
  logic [IDX_W-1:0] rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0] next_ptr_c;

  assign win_c      = IDX_W'(rr_pick(MAX_REQ'(req), MAX_IDX_W'(rr_ptr), 32'(NUM_REQ)));
  assign next_ptr_c = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
`endif

  us_tick_gen #(
    .CLOCK_SPEED_MHZ(CLOCK_SPEED_MHZ)
  ) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (presc_clr_c),
    .en    (state == S_RUN),
    .tick_c(tick_c)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next state and next values of all registered outputs and counters.
  always_comb begin
    state_d     = state;
    grant_d     = grant;
    done_d      = '0;
    busy_d      = busy;
    us_left_d   = us_left;
    owner_d     = owner;
    presc_clr_c = 1'b0;
`ifndef DELAY_ARB_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr;
`endif
    case (state)
      S_IDLE: begin
        if (|req) begin
          owner_d     = win_c;
          grant_d     = NUM_REQ'(1) << win_c;
          us_left_d   = delay_us[win_c*DELAY_W +: DELAY_W];
          presc_clr_c = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (!req[owner]) begin
          // Owner abandoned: release without a done pulse.
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
`ifndef DELAY_ARB_FIXED_PRIO_EN
          rr_ptr_d = next_ptr_c;
`endif
        end else if (us_left == '0) begin
          grant_d = '0;
          done_d  = grant;
          state_d = S_DONE;
`ifndef DELAY_ARB_FIXED_PRIO_EN
          rr_ptr_d = next_ptr_c;
`endif
        end else if (tick_c) begin
          us_left_d = us_left - DELAY_W'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      us_left <= '0;
      owner   <= '0;
    end else begin
      grant   <= grant_d;
      done    <= done_d;
      busy    <= busy_d;
      us_left <= us_left_d;
      owner   <= owner_d;
    end
  end

`ifndef DELAY_ARB_FIXED_PRIO_EN
  // Round-robin pointer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rr_ptr <= '0;
    else        rr_ptr <= rr_ptr_d;
  end
`endif

endmodule
